// File: rtl/weight_bank_writer.sv
// Runtime loader for the first-layer weight store: writes a valid/ready word stream
// filter-major into NUM banks, then serves NUM registered read ports. Optional: WEIGHT_CHECKSUM_EN.
module weight_bank_writer #(
  parameter int WIDTH = 16,
  parameter int NUM   = 64,
  parameter int DEPTH = 27,
  parameter int BADDR = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 load_done,
  input  logic [BADDR-1:0]     rd_addr [0:NUM-1],
  output logic [WIDTH-1:0]     rd_data [0:NUM-1],
`ifdef WEIGHT_CHECKSUM_EN
  output logic [31:0]          checksum,
`endif
  output logic [1:0]           dbg_state
);

  // Handshake: a word transfers on any rising edge where in_valid && in_ready.
  // in_ready is a pure decode of the state register, so it is glitch-free and
  // never depends on in_valid.

  localparam int BW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [BW-1:0]       bank_cnt;
  logic [BADDR-1:0]    addr_cnt;
  logic                xfer;
  logic                addr_last;
  logic                bank_last;
  logic                last_word;
  logic                accept_start;

  logic [WIDTH-1:0]    mem [NUM][DEPTH];

  assign in_ready     = (state == LOAD);
  assign load_done    = (state == DONE);
  assign dbg_state    = state;
  assign xfer         = in_valid && (state == LOAD);
  assign addr_last    = (addr_cnt == BADDR'(DEPTH - 1));
  assign bank_last    = (bank_cnt == BW'(NUM - 1));
  assign last_word    = xfer && addr_last && bank_last;
  assign accept_start = start && (state != LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LOAD;
      LOAD:    if (last_word) state_nxt = DONE;
      DONE:    if (start)     state_nxt = LOAD;
      default:                state_nxt = IDLE;
    endcase
  end

  // Address walks fastest; bank advances when a kernel's DEPTH words are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (accept_start) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (xfer) begin
      if (addr_last) begin
        addr_cnt <= '0;
        bank_cnt <= bank_last ? '0 : bank_cnt + 1'b1;
      end else begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  // Bank contents survive reset; only the stream rewrites them.
  always_ff @(posedge clk) begin
    if (xfer) mem[bank_cnt][addr_cnt] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM; i++) rd_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if ((state == DONE) && (int'(rd_addr[i]) < DEPTH)) rd_data[i] <= mem[i][rd_addr[i]];
        else                                               rd_data[i] <= '0;
      end
    end
  end

`ifdef WEIGHT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              checksum <= '0;
    else if (accept_start) checksum <= '0;
    else if (xfer)         checksum <= checksum + 32'(in_data);
  end
`endif

endmodule

// File: tb/tb_weight_bank_writer.sv
// Directed bench for weight_bank_writer (NUM=4, DEPTH=3, BADDR=2, WIDTH=16);
// also checks the checksum port when WEIGHT_CHECKSUM_EN is defined.
module tb_weight_bank_writer;

  localparam int WIDTH = 16;
  localparam int NUM   = 4;
  localparam int DEPTH = 3;
  localparam int BADDR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              load_done;
  logic [BADDR-1:0]  rd_addr [0:NUM-1];
  logic [WIDTH-1:0]  rd_data [0:NUM-1];
  logic [1:0]        dbg_state;
`ifdef WEIGHT_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] model [NUM][DEPTH];
  logic [31:0]      exp_sum;

  typedef struct {
    logic [0:NUM-1][BADDR-1:0] addr;
    logic [0:NUM-1][WIDTH-1:0] data;
  } vec_t;

  vec_t tv [5];
  vec_t tv_reload;
  vec_t tv_model;

  weight_bank_writer #(
    .WIDTH(WIDTH), .NUM(NUM), .DEPTH(DEPTH), .BADDR(BADDR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .load_done (load_done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`ifdef WEIGHT_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    for (int i = 0; i < NUM; i++)
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_data[i]), 32'd0);
  endtask

  // Drive one read vector, queue its expectations, compare a cycle later.
  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      rd_addr[i] = v.addr[i];
      exp_q.push_back(v.data[i]);
    end
    @(negedge clk);
    for (int i = 0; i < NUM; i++)
      check($sformatf("%s_rd%0d", tag, i), 32'(rd_data[i]), 32'(exp_q.pop_front()));
  endtask

  // Start pulse plus NUM*DEPTH words base, base+1, ...; toggle gaps in_valid on odd cycles.
  task automatic load(input logic [WIDTH-1:0] base, input bit toggle, input bit rd_zero);
    int idx;
    int cyc;
    bit v;
    idx = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    exp_sum = '0;
    while (idx < NUM * DEPTH && cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      check("load_done_low", 32'(load_done), 32'd0);
      check("in_ready_load", 32'(in_ready), 32'd1);
      if (rd_zero && cyc > 0)
        for (int i = 0; i < NUM; i++) check("rd_zero_loading", 32'(rd_data[i]), 32'd0);
      v = !toggle || (cyc % 2 == 0);
      in_valid = v;
      in_data  = v ? base + WIDTH'(idx) : 16'hDEAD;
      if (v) begin
        model[idx / DEPTH][idx % DEPTH] = base + WIDTH'(idx);
        exp_sum = exp_sum + 32'(base + WIDTH'(idx));
        idx++;
      end
      cyc++;
    end
    check("load_word_budget", 32'(idx), 32'(NUM * DEPTH));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    check("load_done_high", 32'(load_done), 32'd1);
    check("in_ready_done", 32'(in_ready), 32'd0);
    check("state_done", 32'(dbg_state), 32'd2);
    if (rd_zero)
      for (int i = 0; i < NUM; i++) check("rd_zero_done_edge", 32'(rd_data[i]), 32'd0);
`ifdef WEIGHT_CHECKSUM_EN
    check("checksum_done", checksum, exp_sum);
`endif
  endtask

  initial begin
    // Expected reads after loading 0x0001..0x000C (bank i = words 3i+1..3i+3)
    tv[0].addr = {2'd2, 2'd0, 2'd1, 2'd2}; tv[0].data = {16'h0003, 16'h0004, 16'h0008, 16'h000C};
    tv[1].addr = {2'd0, 2'd0, 2'd0, 2'd0}; tv[1].data = {16'h0001, 16'h0004, 16'h0007, 16'h000A};
    tv[2].addr = {2'd1, 2'd1, 2'd1, 2'd1}; tv[2].data = {16'h0002, 16'h0005, 16'h0008, 16'h000B};
    tv[3].addr = {2'd3, 2'd3, 2'd3, 2'd3}; tv[3].data = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tv[4].addr = {2'd3, 2'd2, 2'd3, 2'd0}; tv[4].data = {16'h0000, 16'h0006, 16'h0000, 16'h000A};
    tv_reload.addr = {2'd2, 2'd0, 2'd1, 2'd3};
    tv_reload.data = {16'h0102, 16'h0103, 16'h0107, 16'h0000};

    for (int i = 0; i < NUM; i++) rd_addr[i] = '0;

    // Reset, then idle with in_valid high and no start
    repeat (2) @(negedge clk);
    check_idle("reset");
`ifdef WEIGHT_CHECKSUM_EN
    check("reset_checksum", checksum, 32'd0);
`endif
    rst = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle("idle_no_start");
    end
    in_valid = 1'b0;

    // Back-to-back load
    load(16'h0001, 1'b0, 1'b0);
`ifdef WEIGHT_CHECKSUM_EN
    check("checksum_1_to_12", checksum, 32'h0000004E);
`endif
    for (int k = 0; k < 5; k++) apply_vec(tv[k], $sformatf("b2b_v%0d", k));

    // Same stream with in_valid toggling, restarted from DONE
    load(16'h0001, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) apply_vec(tv[k], $sformatf("toggle_v%0d", k));

    // Reload from DONE with new words; reads are zero until DONE
    load(16'h0100, 1'b0, 1'b1);
    apply_vec(tv_reload, "reload_hand");
    tv_model.addr = {2'd2, 2'd2, 2'd2, 2'd2};
    for (int i = 0; i < NUM; i++) tv_model.data[i] = model[i][2];
    apply_vec(tv_model, "reload_model");

    // Reset asserted after the 5th word
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'(k + 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_before_rst", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    #1 check_idle("midload_rst");
`ifdef WEIGHT_CHECKSUM_EN
    check("midload_rst_checksum", checksum, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_rst");

    // Fresh load completes normally
    load(16'h0001, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) apply_vec(tv[k], $sformatf("fresh_v%0d", k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
